// File: rtl/ecl_scan_scheduler.sv
// ecl_scan_scheduler: sequences the IR proximity scan one transmitter at a time.
// Each slot is a whole number of carrier half-periods (HP). The enabled emitter
// sends a modulated burst at the start of the slot. The receiver gate opens after
// a masking window. A one-clock slot_end pulse marks each slot boundary, and the
// scan holds dark while the reporter is still busy with the previous slot.
// Handshake: report_busy is level-sensitive and is sampled only on carrier edges
// at a slot boundary or while holding. The scan leaves HOLD on the first carrier
// edge that sees it low; no acknowledge is returned to the reporter.
module ecl_scan_scheduler #(
  parameter int kClockHz         = 25_000_000,
  parameter int kModulationHz    = 38000,
  parameter int kTxCount         = 12,
  parameter int kBurstMillis     = 20,
  parameter int kRepeatMillis    = 30,
  parameter int kRxMaskingMillis = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [kTxCount-1:0] tx_enable_mask,
  input  logic                report_busy,
  output logic [kTxCount-1:0] ir_tx,
  output logic                mod_phase,
  output logic                rx_gate,
  output logic                slot_end,
  output logic [3:0]          slot_tx,
  output logic [7:0]          stall_count,
  output logic [1:0]          dbg_state
);

  localparam int kHalfDiv  = kClockHz / kModulationHz / 2;
  localparam int kBurstHP  = kBurstMillis * 2 * kModulationHz / 1000;
  localparam int kRepeatHP = kRepeatMillis * 2 * kModulationHz / 1000;
  localparam int kMaskHP   = kRxMaskingMillis * 2 * kModulationHz / 1000;
  localparam int kDivW     = (kHalfDiv > 1) ? $clog2(kHalfDiv) : 1;
  localparam int kHpW      = (kRepeatHP > 1) ? $clog2(kRepeatHP) : 1;

  localparam logic [kDivW-1:0] kDivLast  = kDivW'(kHalfDiv - 1);
  localparam logic [kHpW-1:0]  kHpLast   = kHpW'(kRepeatHP - 1);
  localparam logic [kHpW-1:0]  kBurstEnd = kHpW'(kBurstHP);
  localparam logic [kHpW-1:0]  kMaskEnd  = kHpW'(kMaskHP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SLOT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [kDivW-1:0]    r_div;
  logic [kHpW-1:0]     r_hp;
  logic [kHpW-1:0]     w_hp_nxt;
  logic [3:0]          r_cur_tx;
  logic [3:0]          w_cur_nxt;
  logic                r_mod_phase;
  logic [kTxCount-1:0] r_ir_tx;
  logic                r_rx_gate;
  logic                r_slot_end;
  logic [3:0]          r_slot_tx;
  logic [7:0]          r_stall_count;
  logic                w_mod_edge;
  logic                w_can_go;
  logic                w_slot_done;
  logic                w_stall_inc;
  logic [kTxCount-1:0] w_onehot;

  // Lowest enabled transmitter index (0 when the mask is empty).
  function automatic logic [3:0] f_lowest(input logic [kTxCount-1:0] m);
    f_lowest = '0;
    for (int i = kTxCount - 1; i >= 0; i--) begin
      if (m[i]) f_lowest = 4'(i);
    end
  endfunction

  // Next enabled index above cur, wrapping to the lowest enabled index.
  function automatic logic [3:0] f_next(input logic [kTxCount-1:0] m,
                                        input logic [3:0] cur);
    logic found;
    found  = 1'b0;
    f_next = f_lowest(m);
    for (int i = 0; i < kTxCount; i++) begin
      if (!found && m[i] && (4'(i) > cur)) begin
        f_next = 4'(i);
        found  = 1'b1;
      end
    end
  endfunction

  assign w_mod_edge = (r_div == kDivLast);
  assign w_can_go   = run && (|tx_enable_mask);
  assign w_onehot   = {{(kTxCount-1){1'b0}}, 1'b1} << r_cur_tx;

  // Carrier divider and phase: free-running, never gated by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div       <= '0;
      r_mod_phase <= 1'b0;
    end else if (w_mod_edge) begin
      r_div       <= '0;
      r_mod_phase <= ~r_mod_phase;
    end else begin
      r_div <= r_div + kDivW'(1);
    end
  end

  // Next-state logic: every transition is qualified by the carrier edge.
  always_comb begin
    w_state_nxt = r_state;
    w_hp_nxt    = r_hp;
    w_cur_nxt   = r_cur_tx;
    w_slot_done = 1'b0;
    w_stall_inc = 1'b0;
    if (w_mod_edge) begin
      case (r_state)
        S_IDLE: begin
          if (w_can_go) begin
            w_state_nxt = S_SLOT;
            w_hp_nxt    = '0;
            w_cur_nxt   = f_lowest(tx_enable_mask);
          end
        end
        S_SLOT: begin
          if (r_hp == kHpLast) begin
            w_slot_done = 1'b1;
            if (!w_can_go) begin
              w_state_nxt = S_IDLE;
            end else if (report_busy) begin
              w_state_nxt = S_HOLD;
              w_stall_inc = 1'b1;
            end else begin
              w_hp_nxt  = '0;
              w_cur_nxt = f_next(tx_enable_mask, r_cur_tx);
            end
          end else begin
            w_hp_nxt = r_hp + kHpW'(1);
          end
        end
        S_HOLD: begin
          if (!report_busy) begin
            if (!w_can_go) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_SLOT;
              w_hp_nxt    = '0;
              w_cur_nxt   = f_next(tx_enable_mask, r_cur_tx);
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM state, HP counter and current transmitter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_hp     <= '0;
      r_cur_tx <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_hp     <= w_hp_nxt;
      r_cur_tx <= w_cur_nxt;
    end
  end

  // Registered outputs: emitter drive, receiver gate, slot marker, stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir_tx       <= '0;
      r_rx_gate     <= 1'b0;
      r_slot_end    <= 1'b0;
      r_slot_tx     <= '0;
      r_stall_count <= '0;
    end else begin
      r_ir_tx    <= (r_state == S_SLOT && r_hp < kBurstEnd && r_mod_phase) ? w_onehot : '0;
      r_rx_gate  <= (r_state == S_SLOT) && (r_hp >= kMaskEnd) && !w_slot_done;
      r_slot_end <= w_slot_done;
      if (w_slot_done) r_slot_tx <= r_cur_tx;
      if (w_stall_inc && r_stall_count != 8'hFF) r_stall_count <= r_stall_count + 8'd1;
    end
  end

  assign ir_tx       = r_ir_tx;
  assign mod_phase   = r_mod_phase;
  assign rx_gate     = r_rx_gate;
  assign slot_end    = r_slot_end;
  assign slot_tx     = r_slot_tx;
  assign stall_count = r_stall_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ecl_scan_scheduler.sv
// Bench for ecl_scan_scheduler with a 12-clock slot (2 clocks per HP, 6 HP per slot).
module tb_ecl_scan_scheduler;

  logic        clk;
  logic        rst;
  logic        run;
  logic [11:0] tx_enable_mask;
  logic        report_busy;
  logic [11:0] ir_tx;
  logic        mod_phase;
  logic        rx_gate;
  logic        slot_end;
  logic [3:0]  slot_tx;
  logic [7:0]  stall_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    int   off;
    logic ir_on;
    logic rx_on;
    logic ph;
  } vec_t;
  vec_t slot_tbl[12];

  ecl_scan_scheduler #(
    .kClockHz(4000), .kModulationHz(1000), .kTxCount(12),
    .kBurstMillis(2), .kRepeatMillis(3), .kRxMaskingMillis(1)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .tx_enable_mask(tx_enable_mask),
    .report_busy(report_busy), .ir_tx(ir_tx), .mod_phase(mod_phase),
    .rx_gate(rx_gate), .slot_end(slot_end), .slot_tx(slot_tx),
    .stall_count(stall_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard: every slot_end pops the index expected to have just finished
  always @(negedge clk) begin
    if (!rst && slot_end) begin
      if (exp_q.size() == 0) begin
        chk("slot_end_unexpected", 32'd1, 32'd0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("slot_tx", {28'd0, slot_tx}, {28'd0, e});
      end
    end
  end

  // driver: reset, set inputs, leave the bench on the first sample of the first slot
  task automatic apply_reset(input logic [11:0] m, input logic r);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    rst = 1'b1; run = r; tx_enable_mask = m; report_busy = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  // driver + checker for one slot starting at the current sample point
  task automatic check_slot(input int idx, input bit first,
                            input int mask_at, input logic [11:0] mask_val,
                            input int busy_at, input logic busy_val);
    logic [11:0] exp_ir;
    exp_q.push_back(4'(idx));
    for (int k = 0; k < 12; k++) begin
      exp_ir = slot_tbl[k].ir_on ? (12'h001 << idx) : 12'h000;
      chk("ir_tx", {20'd0, ir_tx}, {20'd0, exp_ir});
      chk("rx_gate", {31'd0, rx_gate}, {31'd0, slot_tbl[k].rx_on});
      chk("mod_phase", {31'd0, mod_phase}, {31'd0, slot_tbl[k].ph});
      chk("slot_end", {31'd0, slot_end}, (k == 0 && !first) ? 32'd1 : 32'd0);
      if (k == 6) chk("state_slot", {30'd0, dbg_state}, 32'd1);
      if (k == mask_at) tx_enable_mask = mask_val;
      if (k == busy_at) report_busy = busy_val;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // sample k: expected ir on, rx_gate, mod_phase (slot starts right after a carrier edge)
    slot_tbl[0]  = '{0,  1'b0, 1'b0, 1'b1};
    slot_tbl[1]  = '{1,  1'b1, 1'b0, 1'b1};
    slot_tbl[2]  = '{2,  1'b1, 1'b0, 1'b0};
    slot_tbl[3]  = '{3,  1'b0, 1'b0, 1'b0};
    slot_tbl[4]  = '{4,  1'b0, 1'b0, 1'b1};
    slot_tbl[5]  = '{5,  1'b1, 1'b1, 1'b1};
    slot_tbl[6]  = '{6,  1'b1, 1'b1, 1'b0};
    slot_tbl[7]  = '{7,  1'b0, 1'b1, 1'b0};
    slot_tbl[8]  = '{8,  1'b0, 1'b1, 1'b1};
    slot_tbl[9]  = '{9,  1'b0, 1'b1, 1'b1};
    slot_tbl[10] = '{10, 1'b0, 1'b1, 1'b0};
    slot_tbl[11] = '{11, 1'b0, 1'b1, 1'b0};

    rst = 1'b0; run = 1'b0; tx_enable_mask = '0; report_busy = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ir_tx", {20'd0, ir_tx}, 32'd0);
    chk("rst_mod_phase", {31'd0, mod_phase}, 32'd0);
    chk("rst_rx_gate", {31'd0, rx_gate}, 32'd0);
    chk("rst_slot_end", {31'd0, slot_end}, 32'd0);
    chk("rst_slot_tx", {28'd0, slot_tx}, 32'd0);
    chk("rst_stall", {24'd0, stall_count}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // full mask: 0..11 then wrap to 0
    apply_reset(12'hFFF, 1'b1);
    for (int s = 0; s < 13; s++) check_slot(s % 12, s == 0, -1, 12'h0, -1, 1'b0);

    // sparse mask
    apply_reset(12'h805, 1'b1);
    check_slot(0, 1, -1, 12'h0, -1, 1'b0);
    check_slot(2, 0, -1, 12'h0, -1, 1'b0);
    check_slot(11, 0, -1, 12'h0, -1, 1'b0);
    check_slot(0, 0, -1, 12'h0, -1, 1'b0);
    check_slot(2, 0, -1, 12'h0, -1, 1'b0);

    // mask cleared mid-slot: slot completes, then idle; single-bit mask restarts
    apply_reset(12'hFFF, 1'b1);
    check_slot(0, 1, -1, 12'h0, -1, 1'b0);
    check_slot(1, 0, -1, 12'h0, -1, 1'b0);
    check_slot(2, 0, 5, 12'h000, -1, 1'b0);
    for (int j = 0; j < 8; j++) begin
      chk("idle_ir_tx", {20'd0, ir_tx}, 32'd0);
      chk("idle_rx_gate", {31'd0, rx_gate}, 32'd0);
      if (j > 0) chk("idle_slot_end", {31'd0, slot_end}, 32'd0);
      if (j == 3) chk("idle_state", {30'd0, dbg_state}, 32'd0);
      if (j == 6) tx_enable_mask = 12'h010;
      @(negedge clk);
    end
    check_slot(4, 1, -1, 12'h0, -1, 1'b0);
    check_slot(4, 0, -1, 12'h0, -1, 1'b0);

    // reporter busy across a slot boundary for 10 clocks
    apply_reset(12'hFFF, 1'b1);
    check_slot(0, 1, -1, 12'h0, -1, 1'b0);
    check_slot(1, 0, -1, 12'h0, 8, 1'b1);
    for (int h = 0; h < 8; h++) begin
      chk("hold_ir_tx", {20'd0, ir_tx}, 32'd0);
      chk("hold_rx_gate", {31'd0, rx_gate}, 32'd0);
      if (h > 0) chk("hold_slot_end", {31'd0, slot_end}, 32'd0);
      if (h == 1) begin
        chk("hold_stall", {24'd0, stall_count}, 32'd1);
        chk("hold_state", {30'd0, dbg_state}, 32'd2);
      end
      if (h == 6) report_busy = 1'b0;
      @(negedge clk);
    end
    check_slot(2, 1, -1, 12'h0, -1, 1'b0);
    chk("stall_after", {24'd0, stall_count}, 32'd1);

    // reset asserted mid-burst takes effect without a clock edge
    apply_reset(12'h0F0, 1'b1);
    check_slot(4, 1, -1, 12'h0, -1, 1'b0);
    @(negedge clk);
    chk("burst_ir_tx", {20'd0, ir_tx}, 32'h020);
    #2 rst = 1'b1;
    #1;
    chk("async_ir_tx", {20'd0, ir_tx}, 32'd0);
    chk("async_mod_phase", {31'd0, mod_phase}, 32'd0);
    chk("async_rx_gate", {31'd0, rx_gate}, 32'd0);
    chk("async_slot_end", {31'd0, slot_end}, 32'd0);
    chk("async_slot_tx", {28'd0, slot_tx}, 32'd0);
    chk("async_state", {30'd0, dbg_state}, 32'd0);
    apply_reset(12'h0F0, 1'b1);
    check_slot(4, 1, -1, 12'h0, -1, 1'b0);
    check_slot(5, 0, -1, 12'h0, -1, 1'b0);

    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
